// File: rtl/ram_pkg.sv
// Shared definitions for the 512x8 dual-port RAM and its burst initiator.
package ram_pkg;

    localparam int unsigned RAM_ADDR_W = 9;
    localparam int unsigned RAM_DATA_W = 8;
    localparam int unsigned RAM_DEPTH  = 512;
    localparam int unsigned RBM_LEN_W  = 8;

    typedef enum logic [1:0] {
        RBM_IDLE  = 2'd0,
        RBM_WR    = 2'd1,
        RBM_RD    = 2'd2,
        RBM_DRAIN = 2'd3
    } rbm_state_t;

endpackage

// File: rtl/rbm_skid_fifo.sv
// Two-entry skid FIFO absorbing RAM read data while the consumer stalls.
module rbm_skid_fifo #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_head,
    output logic [1:0]        o_count,
    output logic              o_empty,
    output logic              o_full
);

    logic [DATA_W-1:0] r_mem [0:1];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage, pointers and occupancy; reset discards any held data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for one port of the 512x8 dual-port RAM.
// Optional macro RBM_BOUNDS_CHECK_EN: reject bursts running past the top
// address with an err pulse instead of wrapping.
module ram_burst_master
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W = RAM_ADDR_W,
    parameter int unsigned DATA_W = RAM_DATA_W,
    parameter int unsigned LEN_W  = RBM_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              err,
    output logic              ram_wren,
    output logic              ram_rden,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_q
);

    rbm_state_t        r_state;
    rbm_state_t        w_state_nxt;
    logic              r_live;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [LEN_W-1:0]  r_beats_left;
    logic              r_inflight;
    logic              r_done;

    logic              w_cmd_acc;
    logic              w_cmd_oob;
    logic              w_last;
    logic              w_wr_beat;
    logic              w_rd_issue;
    logic [1:0]        w_occ;
    logic              w_pop_hs;
    logic              w_final_pop;
    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic [DATA_W-1:0] w_fifo_head;
    logic [1:0]        w_fifo_count;
    logic              w_fifo_empty;
    logic              w_fifo_full;

    assign w_cmd_acc  = cmd_valid & cmd_ready;
    assign w_last     = (r_beats_left == '0);
    assign w_wr_beat  = (r_state == RBM_WR) & wdata_valid;
    // In-flight read counts as occupied so a stalled consumer can never overflow the FIFO.
    assign w_occ      = w_fifo_count + {1'b0, r_inflight};
    assign w_rd_issue = (r_state == RBM_RD) & (w_occ < 2'd2);

    // An in-flight word bypasses the empty FIFO, giving one-cycle read latency.
    assign rdata_valid = ~w_fifo_empty | r_inflight;
    assign rdata       = (~w_fifo_empty) ? w_fifo_head : (r_inflight ? ram_q : '0);
    assign w_pop_hs    = rdata_valid & rdata_ready;
    assign w_fifo_push = r_inflight & ~(w_fifo_empty & rdata_ready);
    assign w_fifo_pop  = ~w_fifo_empty & rdata_ready;
    assign w_final_pop = (r_state == RBM_DRAIN) & w_pop_hs & (w_occ == 2'd1);
    assign done        = r_done;

`ifdef RBM_BOUNDS_CHECK_EN
    localparam int unsigned SUM_W = ADDR_W + 1;
    logic [SUM_W-1:0] w_end_addr;
    logic             r_err;

    assign w_end_addr = SUM_W'(cmd_addr) + SUM_W'(cmd_len);
    assign w_cmd_oob  = (w_end_addr > SUM_W'((1 << ADDR_W) - 1));
    assign err        = r_err;

    // One-cycle err pulse for an accepted but out-of-range command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_cmd_acc & w_cmd_oob;
        end
    end
`else
    assign w_cmd_oob = 1'b0;
    assign err       = 1'b0;
`endif

    rbm_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_skid_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_fifo_push),
        .i_push_data (ram_q),
        .i_pop       (w_fifo_pop),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RBM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RBM_IDLE: begin
                if (w_cmd_acc && !w_cmd_oob) begin
                    w_state_nxt = cmd_write ? RBM_WR : RBM_RD;
                end
            end
            RBM_WR: begin
                if (w_wr_beat && w_last) begin
                    w_state_nxt = RBM_IDLE;
                end
            end
            RBM_RD: begin
                if (w_rd_issue && w_last) begin
                    w_state_nxt = RBM_DRAIN;
                end
            end
            RBM_DRAIN: begin
                if (w_final_pop) begin
                    w_state_nxt = RBM_IDLE;
                end
            end
            default: w_state_nxt = RBM_IDLE;
        endcase
    end

    // Handshake and RAM port outputs; writes pass straight through to the RAM.
    always_comb begin
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        ram_wren    = 1'b0;
        ram_rden    = 1'b0;
        ram_address = r_cur_addr;
        ram_data    = '0;
        case (r_state)
            RBM_IDLE: begin
                cmd_ready = r_live;
            end
            RBM_WR: begin
                wdata_ready = 1'b1;
                ram_wren    = w_wr_beat;
                ram_data    = wdata;
            end
            RBM_RD: begin
                ram_rden = w_rd_issue;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    // Burst address/beat counters, read in-flight flag and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live       <= 1'b0;
            r_cur_addr   <= '0;
            r_beats_left <= '0;
            r_inflight   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_live     <= 1'b1;
            r_inflight <= w_rd_issue;
            r_done     <= (w_wr_beat & w_last) | w_final_pop;
            if ((r_state == RBM_IDLE) && w_cmd_acc) begin
                r_cur_addr   <= cmd_addr;
                r_beats_left <= cmd_len;
            end else if (w_wr_beat || w_rd_issue) begin
                r_cur_addr   <= r_cur_addr + ADDR_W'(1);
                r_beats_left <= r_beats_left - LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master with a behavioural RAM and memory model.
`timescale 1ns/1ps
module tb_ram_burst_master;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_write;
    logic [8:0] cmd_addr;
    logic [7:0] cmd_len;
    logic       wdata_valid, wdata_ready;
    logic [7:0] wdata;
    logic       rdata_valid, rdata_ready;
    logic [7:0] rdata;
    logic       done, err;
    logic       ram_wren, ram_rden;
    logic [8:0] ram_address;
    logic [7:0] ram_data, ram_q;

    logic [7:0] ram_mem [0:511];
    logic [7:0] ref_mem [0:511];

    int unsigned cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          both_cnt = 0;
    int unsigned acc_cyc = 0;

    logic [8:0]  wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    int unsigned wr_cyc_q [$];
    int unsigned rden_cyc_q [$];
    int unsigned valid_cyc_q [$];
    logic [7:0]  rd_data_q [$];
    int unsigned pop_cyc_q [$];
    int unsigned done_cyc_q [$];
    int unsigned err_cyc_q [$];

    ram_burst_master dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .done        (done),
        .err         (err),
        .ram_wren    (ram_wren),
        .ram_rden    (ram_rden),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_q       (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM port: registered read data, visible the cycle after ram_rden.
    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_address] <= ram_data;
        if (ram_rden) ram_q <= ram_mem[ram_address];
    end

    // Event recorder sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_wren) begin
            wr_addr_q.push_back(ram_address);
            wr_data_q.push_back(ram_data);
            wr_cyc_q.push_back(cyc);
        end
        if (ram_rden) rden_cyc_q.push_back(cyc);
        if (ram_wren && ram_rden) both_cnt++;
        if (rdata_valid) valid_cyc_q.push_back(cyc);
        if (rdata_valid && rdata_ready) begin
            rd_data_q.push_back(rdata);
            pop_cyc_q.push_back(cyc);
        end
        if (done) done_cyc_q.push_back(cyc);
        if (err) err_cyc_q.push_back(cyc);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want test completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        rden_cyc_q.delete(); valid_cyc_q.delete(); rd_data_q.delete();
        pop_cyc_q.delete(); done_cyc_q.delete(); err_cyc_q.delete();
    endtask

    task automatic send_cmd(input bit w, input int a, input int l);
        bit ok;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = 9'(a);
        cmd_len   = 8'(l);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (cmd_ready) begin
                ok      = 1'b1;
                acc_cyc = cyc;
                break;
            end
            tick();
        end
        tick();
        cmd_valid = 1'b0;
        check("cmd_accept", 32'(ok), 32'd1);
    endtask

    task automatic write_burst(input int a, input int l, input int gap, input bit fixed);
        logic [7:0] d [$];
        int beat;
        for (int i = 0; i <= l; i++) begin
            d.push_back(fixed ? 8'(8'hA0 + i) : 8'($urandom));
            ref_mem[9'((a + i) % 512)] = d[i];
        end
        clear_mon();
        send_cmd(1'b1, a, l);
        beat = 0;
        for (int n = 0; n < 8 * (l + 1) + 20 && beat <= l; n++) begin
            wdata_valid = ($urandom_range(99) >= 32'(gap));
            wdata       = d[beat];
            @(negedge clk); #1;
            if (wdata_valid && wdata_ready) beat++;
            tick();
        end
        wdata_valid = 1'b0;
        tick(); tick(); tick();
        check("wr_beats_taken", 32'(beat), 32'(l + 1));
        check("wr_count", wr_addr_q.size(), 32'(l + 1));
        for (int i = 0; i <= l; i++) begin
            if (i < wr_addr_q.size()) begin
                check("wr_addr", 32'(wr_addr_q[i]), 32'((a + i) % 512));
                check("wr_data", 32'(wr_data_q[i]), 32'(d[i]));
            end
        end
        check("wr_done_count", done_cyc_q.size(), 32'd1);
        if (done_cyc_q.size() > 0 && wr_cyc_q.size() > 0)
            check("wr_done_timing", done_cyc_q[0], wr_cyc_q[$] + 1);
        if (gap == 0 && wr_cyc_q.size() > 0)
            check("wr_back_to_back", wr_cyc_q[$] - wr_cyc_q[0], 32'(l));
        check("wr_no_rden", rden_cyc_q.size(), 32'd0);
        check("wr_no_err", err_cyc_q.size(), 32'd0);
    endtask

    task automatic read_burst(input int a, input int l, input int mode);
        int mx;
        int iss;
        int pp;
        clear_mon();
        rdata_ready = 1'b1;
        send_cmd(1'b0, a, l);
        for (int n = 0; n < 6 * (l + 1) + 30; n++) begin
            case (mode)
                0:       rdata_ready = 1'b1;
                1:       rdata_ready = n[0];
                default: rdata_ready = ($urandom_range(99) < 70);
            endcase
            @(negedge clk); #1;
            if (done_cyc_q.size() != 0) break;
            tick();
        end
        tick();
        rdata_ready = 1'b1;
        tick(); tick();
        check("rd_count", rd_data_q.size(), 32'(l + 1));
        for (int i = 0; i <= l; i++) begin
            if (i < rd_data_q.size())
                check("rd_data", 32'(rd_data_q[i]), 32'(ref_mem[9'((a + i) % 512)]));
        end
        check("rd_issue_count", rden_cyc_q.size(), 32'(l + 1));
        check("rd_done_count", done_cyc_q.size(), 32'd1);
        if (done_cyc_q.size() > 0 && pop_cyc_q.size() > 0)
            check("rd_done_timing", done_cyc_q[0], pop_cyc_q[$] + 1);
        if (rden_cyc_q.size() > 0 && valid_cyc_q.size() > 0)
            check("rd_latency", valid_cyc_q[0], rden_cyc_q[0] + 1);
        if (mode == 0 && pop_cyc_q.size() > 0)
            check("rd_throughput", pop_cyc_q[$] - pop_cyc_q[0], 32'(l));
        mx = 0;
        if (rden_cyc_q.size() > 0 && pop_cyc_q.size() > 0) begin
            for (int unsigned c = rden_cyc_q[0]; c <= pop_cyc_q[$]; c++) begin
                iss = 0;
                pp  = 0;
                foreach (rden_cyc_q[k]) if (rden_cyc_q[k] <= c) iss++;
                foreach (pop_cyc_q[k]) if (pop_cyc_q[k] < c) pp++;
                if (iss - pp > mx) mx = iss - pp;
            end
        end
        check("rd_occupancy_le2", 32'(mx <= 2), 32'd1);
        check("rd_no_wren", wr_addr_q.size(), 32'd0);
        check("rd_no_err", err_cyc_q.size(), 32'd0);
    endtask

    initial begin
        int a;
        int l;
        cmd_valid   = 1'b0;
        cmd_write   = 1'b0;
        cmd_addr    = '0;
        cmd_len     = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rdata_ready = 1'b1;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;

        // Reset: all outputs low for three cycles, cmd_ready after release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            check("reset_outputs_zero",
                  32'({cmd_ready, wdata_ready, rdata_valid, rdata, done, err,
                       ram_wren, ram_rden, ram_address, ram_data}), 32'd0);
        end
        tick();
        rst_n = 1'b1;
        tick();
        check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

        // Directed write and read bursts.
        write_burst(32'h010, 3, 0, 1'b1);
        read_burst(32'h010, 3, 0);

        // Backpressure with toggling rdata_ready.
        write_burst(32'h010, 7, 0, 1'b0);
        read_burst(32'h010, 7, 1);

        // Address wrap or bounds rejection.
`ifdef RBM_BOUNDS_CHECK_EN
        clear_mon();
        send_cmd(1'b1, 32'h1FE, 3);
        tick(); tick(); tick(); tick();
        check("oob_err_count", err_cyc_q.size(), 32'd1);
        if (err_cyc_q.size() > 0)
            check("oob_err_timing", err_cyc_q[0], acc_cyc + 1);
        check("oob_no_wren", wr_addr_q.size(), 32'd0);
        check("oob_no_done", done_cyc_q.size(), 32'd0);
        check("oob_cmd_ready", 32'(cmd_ready), 32'd1);
`else
        write_burst(32'h1FE, 3, 0, 1'b0);
        read_burst(32'h1FE, 3, 0);
`endif

        // Mid-burst reset during a read.
        clear_mon();
        rdata_ready = 1'b1;
        send_cmd(1'b0, 32'h010, 7);
        for (int n = 0; n < 40 && pop_cyc_q.size() < 2; n++) begin
            @(negedge clk); #1;
            if (pop_cyc_q.size() >= 2) break;
            tick();
        end
        check("midrst_reached_beat2", 32'(pop_cyc_q.size() >= 2), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_rdata_valid_low", 32'(rdata_valid), 32'd0);
        clear_mon();
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("midrst_no_done", done_cyc_q.size(), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        write_burst(32'h040, 5, 20, 1'b0);
        read_burst(32'h040, 5, 2);

        // Randomized bursts, including one maximum-length burst.
        for (int it = 0; it < 6; it++) begin
            l = (it == 0) ? 255 : int'($urandom_range(0, 40));
`ifdef RBM_BOUNDS_CHECK_EN
            a = int'($urandom_range(0, 32'(511 - l)));
`else
            a = int'($urandom_range(0, 511));
`endif
            write_burst(a, l, int'($urandom_range(0, 50)), 1'b0);
            read_burst(a, l, it % 3);
        end

        check("never_wren_and_rden", 32'(both_cnt), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_burst_master.md
Name: ram_burst_master

Overview:
- Initiator for one port of the team's 512x8 true dual-port RAM.
- Accepts burst commands (write or read, start address, length) on a valid/ready interface and drives the RAM port signals: wren, rden, address, data.
- Streams write data in and read data out on valid/ready channels.
- Handles the RAM's one-cycle registered-address read latency and read-side backpressure.

Parameters:
- ADDR_W, 9, RAM address width (512 words).
- DATA_W, 8, RAM word width.
- LEN_W, 8, burst length field width; cmd_len encodes beats-1, so 1..256 beats.

Ports:
- clk, input, 1, single clock; the RAM port clock is tied to the same net.
- rst_n, input, 1, reset, asynchronous, active-low.
- cmd_valid, input, 1, command offered.
- cmd_ready, output, 1, command accepted when both valid and ready are high.
- cmd_write, input, 1, 1 = write burst, 0 = read burst.
- cmd_addr, input, ADDR_W, burst start address.
- cmd_len, input, LEN_W, number of beats minus 1.
- wdata_valid, input, 1, write beat offered.
- wdata_ready, output, 1, write beat accepted.
- wdata, input, DATA_W, write beat data.
- rdata_valid, output, 1, read beat available.
- rdata_ready, input, 1, consumer accepts read beat.
- rdata, output, DATA_W, read beat data.
- done, output, 1, one-cycle pulse at burst completion.
- err, output, 1, one-cycle pulse on a rejected command (only with the optional feature; tied 0 otherwise).
- ram_wren, output, 1, RAM write enable.
- ram_rden, output, 1, RAM read enable (RAM latches the address).
- ram_address, output, ADDR_W, RAM address.
- ram_data, output, DATA_W, RAM write data.
- ram_q, input, DATA_W, RAM read data, valid the cycle after ram_rden.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE; address and beat counters 0; skid FIFO empty.
  - All outputs 0, including cmd_ready. cmd_ready rises the first cycle after rst_n deasserts.
- States: IDLE, WR, RD, DRAIN.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch cmd_addr into cur_addr and cmd_len into beats_left.
  - Next state is WR if cmd_write = 1, otherwise RD.
- WR:
  - wdata_ready = 1.
  - Each beat with wdata_valid = 1 drives ram_wren = 1, ram_address = cur_addr, ram_data = wdata in the same cycle (combinational pass-through).
  - After each beat, cur_addr increments and beats_left decrements.
  - On the beat where beats_left = 0: done pulses the next cycle and the state returns to IDLE.
  - wdata_valid low inserts idle cycles; no RAM write occurs in those cycles.
- RD:
  - ram_rden = 1 when (fifo_count + inflight) < 2; ram_address = cur_addr.
  - One cycle after ram_rden, ram_q is pushed into a 2-entry skid FIFO.
  - rdata and rdata_valid come from the FIFO head; a pop occurs on rdata_valid AND rdata_ready.
  - After the last issue, the state moves to DRAIN.
- DRAIN:
  - Waits until the FIFO is empty and nothing is in flight.
  - done pulses in the cycle after the final pop, then the state returns to IDLE.
- Timing:
  - Read latency from first ram_rden to rdata_valid is 1 cycle.
  - With rdata_ready held at 1, throughput is 1 beat per cycle.
- Address wrap: cur_addr wraps 511 -> 0 (modulo 2^ADDR_W) when the optional feature is absent.
- Concurrency:
  - cmd_ready = 0 outside IDLE, so only one burst is outstanding.
  - A new command is accepted no earlier than the cycle done pulses.
- ram_wren and ram_rden are never both 1 in the same cycle.
- Asserting rst_n low mid-burst aborts immediately: FIFO contents are discarded and no done pulse is issued.

Optional Feature:
- Macro: RBM_BOUNDS_CHECK_EN.
- Defined:
  - A command with cmd_addr + cmd_len > 2^ADDR_W - 1 is accepted (cmd_ready handshake completes) but not executed.
  - err pulses for 1 cycle, no RAM access occurs, no done pulse is issued, and the state stays IDLE.
- Undefined:
  - err is tied 0.
  - Bursts wrap the address past 511.

Decomposition:
- Shared package ram_pkg:
  - RAM_ADDR_W = 9, RAM_DATA_W = 8, RAM_DEPTH = 512.
  - State enum type rbm_state_t.
- One sub-module: rbm_skid_fifo, a 2-entry, DATA_W-wide FIFO providing push, pop, count, empty and full.

Test Plan:
- Reset: rst_n low for 3 cycles -> all outputs 0; cmd_ready = 1 one cycle after release.
- Write burst: addr = 0x010, len = 3, wdata 0xA0..0xA3 back-to-back -> ram_wren on 4 consecutive cycles at addresses 0x010..0x013; done pulses the cycle after the 4th beat.
- Read burst: preload 0x010..0x013, read len = 3 with rdata_ready = 1 -> rdata 0xA0..0xA3 on consecutive cycles, first rdata_valid 1 cycle after first ram_rden; then done.
- Backpressure: read len = 7 with rdata_ready toggling 1/0 -> no beat lost or duplicated; fifo_count + inflight never exceeds 2.
- Wrap: write addr = 0x1FE, len = 3 -> addresses 0x1FE, 0x1FF, 0x000, 0x001. With RBM_BOUNDS_CHECK_EN defined -> err pulse, no ram_wren.
- Mid-burst reset: rst_n low during beat 2 of a read len = 7 -> rdata_valid = 0 immediately; no done pulse; the next command runs normally.
